// File: rtl/ariane_pkg.sv
// ariane_pkg: shared core types. This slice holds the fence-class opcode
// carried from commit port 0 to the fence sequencer.
package ariane_pkg;

    typedef enum logic [1:0] {
        FENCE      = 2'd0,
        FENCE_I    = 2'd1,
        SFENCE_VMA = 2'd2,
        FLUSH_DC   = 2'd3
    } fence_op_t;

endpackage

// File: rtl/fence_sequencer_if.sv
// fence_sequencer_if: commit-side request/kill, store-buffer status, D$ flush
// handshake and the sequencer's command/status outputs.
// master = commit/cache side, slave = fence_sequencer.
interface fence_sequencer_if;
    import ariane_pkg::*;

    logic      req_valid_i;
    fence_op_t req_op_i;
    logic      kill_i;
    logic      no_st_pending_i;
    logic      dcache_flush_o;
    logic      dcache_flush_ack_i;
    logic      icache_flush_o;
    logic      tlb_flush_o;
    logic      flush_pipeline_o;
    logic      done_o;
    logic      busy_o;
    logic      timeout_o;

    modport master (
        output req_valid_i, req_op_i, kill_i, no_st_pending_i, dcache_flush_ack_i,
        input  dcache_flush_o, icache_flush_o, tlb_flush_o, flush_pipeline_o,
               done_o, busy_o, timeout_o
    );

    modport slave (
        input  req_valid_i, req_op_i, kill_i, no_st_pending_i, dcache_flush_ack_i,
        output dcache_flush_o, icache_flush_o, tlb_flush_o, flush_pipeline_o,
               done_o, busy_o, timeout_o
    );

endinterface

// File: rtl/fence_sequencer.sv
// fence_sequencer: retires fence-class instructions by draining the store
// buffer, optionally flushing the D$, then pulsing the follow-up flush
// commands and the commit acknowledge in a single DONE cycle.
// Optional store-drain watchdog: define FENCE_SEQ_TIMEOUT_EN.
module fence_sequencer
    import ariane_pkg::*;
#(
    parameter int unsigned DRAIN_TIMEOUT        = 1024,
    parameter bit          FENCE_FLUSHES_DCACHE = 1'b1
) (
    input logic              clk_i,
    input logic              rst_i,
    fence_sequencer_if.slave bus
);

    typedef enum logic [1:0] {IDLE, DRAIN, DC_FLUSH, DONE} state_e;

    state_e    state_q;
    fence_op_t op_q;
    logic      killed_q;
    logic      dcache_flush_q;
    logic      icache_flush_q;
    logic      tlb_flush_q;
    logic      flush_pipeline_q;
    logic      done_q;

    logic      skip_dc_flush;
    logic      enter_done;

    // Route decisions for the latched op and the DONE entry condition
    always_comb begin
        skip_dc_flush = (op_q == SFENCE_VMA) || ((op_q == FENCE) && !FENCE_FLUSHES_DCACHE);
        enter_done    = ((state_q == DRAIN) && !bus.kill_i && bus.no_st_pending_i && skip_dc_flush)
                      || ((state_q == DC_FLUSH) && bus.dcache_flush_ack_i);
    end

    // Request sequencing; command pulses are registered on the transition into DONE
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= IDLE;
            op_q             <= FENCE;
            killed_q         <= 1'b0;
            dcache_flush_q   <= 1'b0;
            icache_flush_q   <= 1'b0;
            tlb_flush_q      <= 1'b0;
            flush_pipeline_q <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            icache_flush_q   <= 1'b0;
            tlb_flush_q      <= 1'b0;
            flush_pipeline_q <= 1'b0;
            done_q           <= 1'b0;
            // A kill arriving in the same cycle as the flush ack still counts as killed.
            if (enter_done) begin
                done_q           <= !(killed_q || bus.kill_i);
                flush_pipeline_q <= !(killed_q || bus.kill_i);
                tlb_flush_q      <= (op_q == SFENCE_VMA);
                icache_flush_q   <= (op_q == FENCE_I) || (op_q == FLUSH_DC);
            end
            case (state_q)
                IDLE: begin
                    if (bus.req_valid_i && !bus.kill_i) begin
                        op_q    <= bus.req_op_i;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.kill_i) begin
                        state_q <= IDLE;
                    end else if (bus.no_st_pending_i) begin
                        if (skip_dc_flush) begin
                            state_q <= DONE;
                        end else begin
                            state_q        <= DC_FLUSH;
                            dcache_flush_q <= 1'b1;
                        end
                    end
                end
                DC_FLUSH: begin
                    if (bus.kill_i) begin
                        killed_q <= 1'b1;
                    end
                    if (bus.dcache_flush_ack_i) begin
                        state_q        <= DONE;
                        dcache_flush_q <= 1'b0;
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    killed_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.dcache_flush_o   = dcache_flush_q;
    assign bus.icache_flush_o   = icache_flush_q;
    assign bus.tlb_flush_o      = tlb_flush_q;
    assign bus.flush_pipeline_o = flush_pipeline_q;
    assign bus.done_o           = done_q;
    assign bus.busy_o           = (state_q != IDLE);

`ifdef FENCE_SEQ_TIMEOUT_EN
    localparam int unsigned          CNT_W     = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]     CNT_LIMIT = CNT_W'(DRAIN_TIMEOUT);

    logic [CNT_W-1:0] drain_cnt_q;
    logic             timeout_q;
    logic             drain_exit;

    assign drain_exit = bus.kill_i || bus.no_st_pending_i;

    // Count cycles spent in DRAIN; the sticky flag sets as the count reaches the limit
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drain_cnt_q <= '0;
            timeout_q   <= 1'b0;
        end else if (state_q == DRAIN) begin
            if (drain_cnt_q == CNT_LIMIT - 1'b1) begin
                timeout_q <= 1'b1;
            end
            if (drain_exit) begin
                drain_cnt_q <= '0;
            end else if (drain_cnt_q != CNT_LIMIT) begin
                drain_cnt_q <= drain_cnt_q + 1'b1;
            end
        end
    end

    assign bus.timeout_o = timeout_q;
`else
    // Watchdog compiled out; keep the limit parameter referenced.
    logic unused_drain_timeout;
    assign unused_drain_timeout = ^DRAIN_TIMEOUT;
    assign bus.timeout_o        = 1'b0;
`endif

endmodule

// File: tb/tb_fence_sequencer.sv
// tb_fence_sequencer: two sequencers (D$-flushing FENCE and drain-only FENCE)
// share one directed stimulus stream; a request-level reference model is
// compared every cycle, and directed scenarios pin literal expectations.
module tb_fence_sequencer;
    import ariane_pkg::*;

    localparam int unsigned TMO = 8;
`ifdef FENCE_SEQ_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic      clk;
    logic      rst;
    logic      req_valid;
    fence_op_t req_op;
    logic      kill;
    logic      no_st;
    logic      ack;

    int checks = 0;
    int errors = 0;

    fence_sequencer_if bus_a ();
    fence_sequencer_if bus_b ();

    assign bus_a.req_valid_i        = req_valid;
    assign bus_a.req_op_i           = req_op;
    assign bus_a.kill_i             = kill;
    assign bus_a.no_st_pending_i    = no_st;
    assign bus_a.dcache_flush_ack_i = ack;
    assign bus_b.req_valid_i        = req_valid;
    assign bus_b.req_op_i           = req_op;
    assign bus_b.kill_i             = kill;
    assign bus_b.no_st_pending_i    = no_st;
    assign bus_b.dcache_flush_ack_i = ack;

    fence_sequencer #(.DRAIN_TIMEOUT(TMO), .FENCE_FLUSHES_DCACHE(1'b1)) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(bus_a)
    );
    fence_sequencer #(.DRAIN_TIMEOUT(TMO), .FENCE_FLUSHES_DCACHE(1'b0)) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: per DUT, one outstanding request and what it still waits on.
    // ph: 0 no request, 1 waiting for stores, 2 waiting for D$ ack, 3 retiring
    int        ph      [2];
    fence_op_t m_op    [2];
    bit        m_kill  [2];
    int        m_cnt   [2];
    bit        m_tmo   [2];
    logic [3:0] m_pulse[2];   // {icache, tlb, flush_pipeline, done}

    task automatic retire(input int i);
        ph[i]      = 3;
        m_pulse[i] = {(m_op[i] == FENCE_I) || (m_op[i] == FLUSH_DC), m_op[i] == SFENCE_VMA,
                      !m_kill[i], !m_kill[i]};
    endtask

    task automatic model_step(input int i);
        bit ffd;
        ffd        = (i == 0);
        m_pulse[i] = 4'b0000;
        case (ph[i])
            0: if (req_valid && !kill) begin
                ph[i]     = 1;
                m_op[i]   = req_op;
                m_kill[i] = 1'b0;
            end
            1: begin
                m_cnt[i]++;
                if (TMO_EN && m_cnt[i] >= TMO) m_tmo[i] = 1'b1;
                if (kill) begin
                    ph[i]    = 0;
                    m_cnt[i] = 0;
                end else if (no_st) begin
                    m_cnt[i] = 0;
                    if (m_op[i] == SFENCE_VMA || (m_op[i] == FENCE && !ffd)) retire(i);
                    else ph[i] = 2;
                end
            end
            2: begin
                if (kill) m_kill[i] = 1'b1;
                if (ack) retire(i);
            end
            default: begin
                ph[i]     = 0;
                m_kill[i] = 1'b0;
            end
        endcase
    endtask

    // Advance the reference model on every clock edge, or reset it immediately
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                ph[i]      = 0;
                m_kill[i]  = 1'b0;
                m_cnt[i]   = 0;
                m_tmo[i]   = 1'b0;
                m_pulse[i] = 4'b0000;
            end else begin
                model_step(i);
            end
        end
    end

    function automatic logic [6:0] expected(input int i);
        return {ph[i] != 0, ph[i] == 2, m_pulse[i], m_tmo[i]};
    endfunction

    // Compare all outputs of both DUTs against the model, mid-cycle
    always @(negedge clk) begin
        check("cycle_outs_a", {bus_a.busy_o, bus_a.dcache_flush_o, bus_a.icache_flush_o,
              bus_a.tlb_flush_o, bus_a.flush_pipeline_o, bus_a.done_o, bus_a.timeout_o},
              expected(0));
        check("cycle_outs_b", {bus_b.busy_o, bus_b.dcache_flush_o, bus_b.icache_flush_o,
              bus_b.tlb_flush_o, bus_b.flush_pipeline_o, bus_b.done_o, bus_b.timeout_o},
              expected(1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n_dc;
        int done_at;
        int done_at_b;
        int dc_b;
        logic ic_at;
        logic [4:0] seen;

        rst = 1'b1; req_valid = 1'b0; req_op = FENCE; kill = 1'b0; no_st = 1'b0; ack = 1'b0;
        tick();
        @(negedge clk);
        check("reset_outs_a", {bus_a.busy_o, bus_a.dcache_flush_o, bus_a.icache_flush_o,
              bus_a.tlb_flush_o, bus_a.flush_pipeline_o, bus_a.done_o, bus_a.timeout_o}, 7'd0);
        tick();
        rst = 1'b0;
        tick();

        // SFENCE_VMA with an empty store buffer; req_valid again in DONE is ignored
        no_st = 1'b1;
        tick(); req_valid = 1'b1; req_op = SFENCE_VMA;
        @(negedge clk); check("sf_c0_busy", bus_a.busy_o, 1'b0);
        tick(); req_valid = 1'b0; req_op = FENCE;
        @(negedge clk); check("sf_c1_busy", bus_a.busy_o, 1'b1);
        check("sf_c1_done", bus_a.done_o, 1'b0);
        tick(); req_valid = 1'b1;
        @(negedge clk);
        check("sf_c2_a", {bus_a.done_o, bus_a.tlb_flush_o, bus_a.flush_pipeline_o,
              bus_a.icache_flush_o, bus_a.dcache_flush_o}, 5'b11100);
        check("sf_c2_b", {bus_b.done_o, bus_b.tlb_flush_o, bus_b.flush_pipeline_o,
              bus_b.icache_flush_o, bus_b.dcache_flush_o}, 5'b11100);
        tick(); req_valid = 1'b0;
        @(negedge clk); check("sf_c3_idle", bus_a.busy_o, 1'b0);

        // Stray ack while idle, then FENCE_I with pending stores and a late ack
        tick(); ack = 1'b1;
        tick(); ack = 1'b0; no_st = 1'b0; req_valid = 1'b1; req_op = FENCE_I;
        tick(); req_valid = 1'b0; req_op = SFENCE_VMA;
        tick(); tick(); tick();
        tick(); no_st = 1'b1;
        n_dc = 0; done_at = -1; ic_at = 1'b0;
        for (int c = 6; c <= 12; c++) begin
            tick(); ack = (c == 9);
            @(negedge clk);
            if (bus_a.dcache_flush_o) n_dc++;
            if (bus_a.done_o) begin
                done_at = c;
                ic_at   = bus_a.icache_flush_o;
                check("fi_tlb_at_done", bus_a.tlb_flush_o, 1'b0);
            end
        end
        check("fi_dc_high_cycles", n_dc, 4);
        check("fi_done_cycle", done_at, 10);
        check("fi_icache_at_done", ic_at, 1'b1);

        // FENCE: drain-only build finishes at cycle 2, flushing build waits for ack
        tick(); req_valid = 1'b1; req_op = FENCE;
        done_at = -1; done_at_b = -1; dc_b = 0;
        for (int c = 1; c <= 6; c++) begin
            tick(); req_valid = 1'b0; ack = (c == 3);
            @(negedge clk);
            if (bus_a.done_o) done_at = c;
            if (bus_b.done_o) done_at_b = c;
            if (bus_b.dcache_flush_o) dc_b++;
        end
        check("fence_b_done_cycle", done_at_b, 2);
        check("fence_b_dc_never", dc_b, 0);
        check("fence_a_done_cycle", done_at, 4);

        // Kill while draining: back to idle with no pulses
        tick(); req_valid = 1'b1; req_op = FLUSH_DC; no_st = 1'b0;
        seen = '0;
        for (int c = 1; c <= 6; c++) begin
            tick(); req_valid = 1'b0; kill = (c == 2); no_st = (c >= 4);
            @(negedge clk);
            seen |= {bus_a.done_o, bus_a.icache_flush_o, bus_a.tlb_flush_o,
                     bus_a.flush_pipeline_o, bus_a.dcache_flush_o};
            if (c == 3) check("kd_idle_c3", bus_a.busy_o, 1'b0);
        end
        check("kd_no_pulses", seen, 5'b00000);

        // Kill during the D$ flush: flush completes, only icache_flush_o fires
        tick(); req_valid = 1'b1; req_op = FLUSH_DC; no_st = 1'b1;
        seen = '0; done_at = -1;
        for (int c = 1; c <= 7; c++) begin
            tick(); req_valid = 1'b0; kill = (c == 3); ack = (c == 4);
            @(negedge clk);
            seen |= {bus_a.done_o, 1'b0, bus_a.tlb_flush_o, bus_a.flush_pipeline_o, 1'b0};
            if (bus_a.icache_flush_o) done_at = c;
        end
        check("kf_suppressed", seen, 5'b00000);
        check("kf_icache_cycle", done_at, 5);

        // Killed flag must not leak into the next request
        tick(); req_valid = 1'b1; req_op = SFENCE_VMA;
        tick(); req_valid = 1'b0;
        tick();
        @(negedge clk); check("after_kill_done", bus_a.done_o, 1'b1);

        // Stores pending for 20 cycles: watchdog flags from cycle 9, FSM keeps waiting
        tick(); tick(); req_valid = 1'b1; req_op = SFENCE_VMA; no_st = 1'b0;
        done_at = -1;
        for (int c = 1; c <= 25; c++) begin
            tick(); req_valid = 1'b0; no_st = (c >= 20);
            @(negedge clk);
            if (c == 8) check("tmo_c8", bus_a.timeout_o, 1'b0);
            if (c == 9) check("tmo_c9", bus_a.timeout_o, TMO_EN);
            if (c == 25) check("tmo_sticky", bus_a.timeout_o, TMO_EN);
            if (bus_a.done_o) done_at = c;
        end
        check("tmo_done_cycle", done_at, 21);

        // Reset asserted mid-flush drops everything at once
        tick(); req_valid = 1'b1; req_op = FLUSH_DC; no_st = 1'b1;
        tick(); req_valid = 1'b0;
        tick();
        @(negedge clk); check("rst_pre_dc", bus_a.dcache_flush_o, 1'b1);
        tick(); rst = 1'b1;
        #1;
        check("rst_dc_drop", bus_a.dcache_flush_o, 1'b0);
        check("rst_busy", bus_a.busy_o, 1'b0);
        check("rst_tmo_clear", bus_a.timeout_o, 1'b0);
        tick(); rst = 1'b0;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
